// File: rtl/data_32to128.sv
// Packs 32-bit header beats MSB-first into 138-bit FIFO words {pktID, tag, data}.
// A word that meets a full FIFO is parked in a hold register and input is stalled until it drains.
module data_32to128 #(
  parameter int widthPkt        = 138,
  parameter int widthHeaderData = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       headerData_in_valid,
  input  logic [widthHeaderData-1:0] headerData_in,
  input  logic                       headerData_finish_valid,
  input  logic [7:0]                 pktID_in,
  output logic                       headerIn_ready,
  input  logic                       fifo_full,
  output logic                       wrreq,
  output logic [widthPkt-1:0]        data_out,
  output logic                       protocol_error
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t              r_state;
  logic [1:0]          r_lane;
  logic [127:0]        r_acc;
  logic [widthPkt-1:0] r_hold;
  logic [widthPkt-1:0] r_data_out;
  logic                r_wrreq;
  logic                r_protocol_error;

  logic                w_accept;
  logic                w_complete;
  logic [127:0]        w_beat_ext;
  logic [127:0]        w_data;
  logic [widthPkt-1:0] w_word;

  assign headerIn_ready = (r_state == COLLECT);
  assign w_accept       = headerData_in_valid && headerIn_ready;
  assign w_complete     = w_accept && ((r_lane == 2'd3) || headerData_finish_valid);

  always_comb begin
    w_beat_ext = '0;
    w_beat_ext[widthHeaderData-1:0] = headerData_in;
    // Lane 0 lands in the top 32 bits, lane 3 in the bottom.
    w_data = r_acc | (w_beat_ext << (7'd32 * (7'd3 - {5'd0, r_lane})));
    w_word = '0;
    w_word[127:0] = w_data;
    if (headerData_finish_valid) begin
      w_word[129:128] = 2'b01;
      w_word[137:130] = pktID_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= COLLECT;
      r_lane           <= '0;
      r_acc            <= '0;
      r_hold           <= '0;
      r_data_out       <= '0;
      r_wrreq          <= 1'b0;
      r_protocol_error <= 1'b0;
    end else begin
      r_wrreq          <= 1'b0;
      r_protocol_error <= headerData_in_valid && !headerIn_ready;
      case (r_state)
        COLLECT: begin
          if (w_complete) begin
            r_lane <= '0;
            r_acc  <= '0;
            if (!fifo_full) begin
              r_data_out <= w_word;
              r_wrreq    <= 1'b1;
            end else begin
              // data_out keeps the previous write until the parked word drains.
              r_hold  <= w_word;
              r_state <= HOLD;
            end
          end else if (w_accept) begin
            r_lane <= r_lane + 2'd1;
            r_acc  <= w_data;
          end
        end
        HOLD: begin
          if (!fifo_full) begin
            r_data_out <= r_hold;
            r_wrreq    <= 1'b1;
            r_state    <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign wrreq          = r_wrreq;
  assign data_out       = r_data_out;
  assign protocol_error = r_protocol_error;

endmodule

// File: tb/tb_data_32to128.sv
// Scoreboard bench for data_32to128: expected words are queued as beats are driven
// and compared against every wrreq strobe seen on the falling edge.
module tb_data_32to128;

  logic         clk = 1'b0;
  logic         reset;
  logic         headerData_in_valid;
  logic [31:0]  headerData_in;
  logic         headerData_finish_valid;
  logic [7:0]   pktID_in;
  logic         headerIn_ready;
  logic         fifo_full;
  logic         wrreq;
  logic [137:0] data_out;
  logic         protocol_error;

  int errors = 0;
  int checks = 0;
  logic [137:0] sb[$];

  data_32to128 #(.widthPkt(138), .widthHeaderData(32)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .headerData_in_valid     (headerData_in_valid),
    .headerData_in           (headerData_in),
    .headerData_finish_valid (headerData_finish_valid),
    .pktID_in                (pktID_in),
    .headerIn_ready          (headerIn_ready),
    .fifo_full               (fifo_full),
    .wrreq                   (wrreq),
    .data_out                (data_out),
    .protocol_error          (protocol_error)
  );

  always #5 clk = ~clk;

  // Every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && wrreq !== 1'b0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: wrreq=%b data_out=%h, required no write", wrreq, data_out);
      end else begin
        logic [137:0] exp;
        exp = sb.pop_front();
        if (data_out !== exp) begin
          errors++;
          $display("FAIL write_data: got %h, required %h", data_out, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic fin, input logic [7:0] pid);
    headerData_in_valid     = 1'b1;
    headerData_in           = d;
    headerData_finish_valid = fin;
    pktID_in                = pid;
    tick();
    headerData_in_valid     = 1'b0;
    headerData_finish_valid = 1'b0;
    headerData_in           = $urandom;
    pktID_in                = 8'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d writes outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    headerData_in_valid = 1'b1;
    headerData_finish_valid = 1'b1;
    fifo_full = 1'b0;
    headerData_in = 32'hDEAD_BEEF;
    pktID_in = 8'h77;
    do_reset();
    headerData_in_valid = 1'b0;
    headerData_finish_valid = 1'b0;
    checks++;
    if ({headerIn_ready, wrreq, protocol_error} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctrl: ready/wrreq/perr=%b, required 100", {headerIn_ready, wrreq, protocol_error});
    end
    checks++;
    if (data_out !== '0) begin
      errors++;
      $display("FAIL reset_data: data_out=%h, required 0", data_out);
    end
  endtask

  task automatic test_four_beat();
    logic [31:0] a [4];
    for (int i = 0; i < 4; i++) a[i] = $urandom;
    sb.push_back({8'h5A, 2'b01, a[0], a[1], a[2], a[3]});
    for (int i = 0; i < 4; i++) send_beat(a[i], i == 3, 8'h5A);
    checks++;
    if (wrreq !== 1'b1) begin
      errors++;
      $display("FAIL four_beat_latency: wrreq=%b one cycle after last beat, required 1", wrreq);
    end
    tick();
    checks++;
    if (wrreq !== 1'b0) begin
      errors++;
      $display("FAIL four_beat_single_strobe: wrreq=%b, required 0", wrreq);
    end
    drain("four_beat");
  endtask

  task automatic test_six_beat();
    logic [31:0] w [6];
    for (int i = 0; i < 6; i++) w[i] = $urandom;
    sb.push_back({8'h00, 2'b00, w[0], w[1], w[2], w[3]});
    sb.push_back({8'h11, 2'b01, w[4], w[5], 64'h0});
    for (int i = 0; i < 6; i++) begin
      send_beat(w[i], i == 5, 8'h11);
      if (i == 4) begin
        // idle cycle with finish asserted but no valid: must be ignored
        headerData_finish_valid = 1'b1;
        pktID_in = 8'hEE;
        tick();
        headerData_finish_valid = 1'b0;
      end
    end
    drain("six_beat");
  endtask

  task automatic test_single_beat();
    logic [31:0] w0;
    w0 = $urandom;
    sb.push_back({8'hFF, 2'b01, w0, 96'h0});
    send_beat(w0, 1'b1, 8'hFF);
    drain("single_beat");
  endtask

  task automatic test_hold();
    logic [31:0] a [4];
    for (int i = 0; i < 4; i++) a[i] = $urandom;
    sb.push_back({8'h3C, 2'b01, a[0], a[1], a[2], a[3]});
    for (int i = 0; i < 4; i++) begin
      if (i == 3) fifo_full = 1'b1;
      send_beat(a[i], i == 3, 8'h3C);
    end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (headerIn_ready !== 1'b0 || wrreq !== 1'b0) begin
        errors++;
        $display("FAIL hold_stall: cycle %0d ready=%b wrreq=%b, required 0 0", c, headerIn_ready, wrreq);
      end
      if (c < 2) tick();
    end
    fifo_full = 1'b0;
    tick();
    checks++;
    if (wrreq !== 1'b1 || headerIn_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: wrreq=%b ready=%b, required 1 1", wrreq, headerIn_ready);
    end
    drain("hold");
  endtask

  task automatic test_protocol_error();
    logic [31:0] a [4];
    for (int i = 0; i < 4; i++) a[i] = $urandom;
    sb.push_back({8'hA5, 2'b01, a[0], a[1], a[2], a[3]});
    fifo_full = 1'b1;
    for (int i = 0; i < 4; i++) send_beat(a[i], i == 3, 8'hA5);
    send_beat(32'hBAD0_BAD0, 1'b1, 8'h99);
    checks++;
    if (protocol_error !== 1'b1) begin
      errors++;
      $display("FAIL perr_pulse: protocol_error=%b, required 1", protocol_error);
    end
    tick();
    checks++;
    if (protocol_error !== 1'b0) begin
      errors++;
      $display("FAIL perr_one_cycle: protocol_error=%b, required 0", protocol_error);
    end
    fifo_full = 1'b0;
    drain("perr");
  endtask

  task automatic test_reset_mid();
    logic [31:0] a [4];
    send_beat($urandom, 1'b0, 8'h00);
    send_beat($urandom, 1'b0, 8'h00);
    do_reset();
    for (int i = 0; i < 4; i++) a[i] = $urandom;
    sb.push_back({8'h42, 2'b01, a[0], a[1], a[2], a[3]});
    for (int i = 0; i < 4; i++) send_beat(a[i], i == 3, 8'h42);
    drain("reset_mid");
    // a parked word is discarded by reset as well
    fifo_full = 1'b1;
    send_beat($urandom, 1'b1, 8'h01);
    do_reset();
    fifo_full = 1'b0;
    repeat (3) tick();
    checks++;
    if (headerIn_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold_ready: ready=%b, required 1", headerIn_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [7];
    for (int i = 0; i < 7; i++) w[i] = $urandom;
    sb.push_back({8'h01, 2'b01, w[0], 96'h0});
    sb.push_back({8'h02, 2'b01, w[1], w[2], 64'h0});
    sb.push_back({8'h03, 2'b01, w[3], w[4], w[5], w[6]});
    send_beat(w[0], 1'b1, 8'h01);
    checks++;
    if (headerIn_ready !== 1'b1 || wrreq !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: ready=%b wrreq=%b, required 1 1", headerIn_ready, wrreq);
    end
    send_beat(w[1], 1'b0, 8'h00);
    send_beat(w[2], 1'b1, 8'h02);
    for (int i = 3; i < 7; i++) send_beat(w[i], i == 6, 8'h03);
    drain("b2b");
  endtask

  initial begin
    reset = 1'b1;
    fifo_full = 1'b0;
    headerData_in_valid = 1'b0;
    headerData_finish_valid = 1'b0;
    headerData_in = '0;
    pktID_in = '0;
    test_reset();
    test_four_beat();
    test_six_beat();
    test_single_beat();
    test_hold();
    test_protocol_error();
    test_reset_mid();
    test_back_to_back();
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
